inst_fetch_ctrl: RTL and testbench
==================================

// Module: inst_fetch_ctrl
// PURPOSE
//  Sequences the combinational 64-bit instruction ROM for the IF stage.
//  Owns the fetch PC and drives ROM ce/addr.
//  Buffers fetched words in a small prefetch FIFO.
//  Hands {pc, inst} to decode over a valid/ready handshake.
//  Handles branch/jump redirects by flushing the FIFO and reloading the PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch PC loaded on reset
//  PC_STEP    16             byte increment per instruction; ROM indexes by addr[..:4]
//  FIFO_DEPTH 2              prefetch entries; power of two, >=2
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   reset, asynchronous, active-low (0 = reset)
//  fetch_en       in   1   1 = fetching permitted
//  rom_ce         out  1   ROM chip enable; 1 only in a cycle that pushes
//  rom_addr       out  32  ROM byte address; equals pc when rom_ce=1, else 0
//  rom_inst       in   64  ROM data, valid in the same cycle as rom_addr
//  redirect_valid in   1   1-cycle pulse from EX: take redirect_pc
//  redirect_pc    in   32  new fetch PC; bits[3:0] are forced to 0
//  out_valid      out  1   FIFO head valid
//  out_ready      in   1   decode accepts head this cycle
//  out_inst       out  64  head instruction; 0 when out_valid=0
//  out_pc         out  32  head PC; 0 when out_valid=0
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  current entry count
// BEHAVIOUR
//  Reset (rst=0, async)
//   - state=IDLE, pc=RESET_PC, FIFO emptied.
//   - rom_ce=0, rom_addr=0, out_valid=0, out_inst=0, out_pc=0, fifo_level=0.
//  Definitions
//   - pop  = out_valid & out_ready
//   - push = state==RUN & ~redirect_valid & (level<FIFO_DEPTH | pop)
//   - rom_ce = push, combinational; rom_addr = push ? pc : 0.
//  FSM
//   - IDLE: fetch_en=1 -> RUN at next edge.
//   - RUN:  fetch_en=0 -> IDLE at next edge; FIFO keeps draining in IDLE.
//  Datapath on push edge
//   - Write {pc, rom_inst} at tail.
//   - pc <= pc + PC_STEP; 32-bit wrap at 2^32 (0xFFFF_FFF0 -> 0x0).
//  Pop edge
//   - Head advances; the head word is consumed even if a redirect arrives the same cycle.
//  Simultaneous push+pop at full: allowed; level unchanged.
//  Latency
//   - fetch_en rising at edge E: RUN after E, first push at E+1, out_valid=1 after E+1.
//   - Thereafter up to one instruction per cycle while out_ready=1.
//  Redirect edge (any state)
//   - FIFO cleared (level=0).
//   - pc <= {redirect_pc[31:4], 4'b0}.
//   - No push that cycle; state unchanged.
//   - out_valid=0 in the following cycle.
//   - First redirected word is visible one cycle later if in RUN.
//  Full FIFO with out_ready=0: rom_ce=0, pc holds, outputs stable.
//  Deasserted out_ready: out_inst/out_pc are held stable while out_valid=1.
//  Reset mid-operation: immediate return to reset values; any in-flight or buffered words are lost.
// TESTING
//  T1: Reset, fetch_en=1, out_ready=1.
//      -> rom_addr 0x00,0x10,0x20 on consecutive cycles.
//      -> out_pc 0x00,0x10,0x20 each one cycle later; out_inst matches ROM.
//  T2: out_ready=0 after start.
//      -> level reaches 2 and stays; rom_ce=0.
//      -> Raise out_ready: pops 0x00,0x10, then stream resumes at 0x20 with no gap or duplicate.
//  T3: FIFO full, redirect_valid=1 with redirect_pc=0x47.
//      -> Next cycle out_valid=0, level=0.
//      -> Next out_pc=0x40, then 0x50.
//  T4: pop and redirect in same cycle (head 0x10, redirect 0x80).
//      -> 0x10 consumed once; 0x20 never presented; next out_pc=0x80.
//  T5: fetch_en=0 mid-stream with 2 buffered.
//      -> rom_ce=0 next cycle; both entries drain.
//      -> Re-enable resumes from the saved pc.
//  T6: rst=0 asserted between edges with FIFO non-empty.
//      -> out_valid=0, rom_ce=0 immediately.
//      -> After release + fetch_en, first out_pc=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, drives the combinational instruction ROM,
// and buffers {pc, inst} pairs in a small prefetch FIFO for decode.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned PC_STEP    = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  output logic                          rom_ce,
  output logic [31:0]                   rom_addr,
  input  logic [63:0]                   rom_inst,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [63:0]                   out_inst,
  output logic [31:0]                   out_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthL = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   level_q;
  logic [31:0]     pc_mem   [FIFO_DEPTH];
  logic [63:0]     inst_mem [FIFO_DEPTH];

  logic push, pop;

  assign pop  = (level_q != '0) & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
  assign push = (state_q == StRun) & ~redirect_valid & ((level_q < DepthL) | pop);

  always_comb begin
    rom_ce     = push;
    rom_addr   = push ? pc_q : 32'h0;
    out_valid  = (level_q != '0);
    out_inst   = out_valid ? inst_mem[rd_ptr_q] : 64'h0;
    out_pc     = out_valid ? pc_mem[rd_ptr_q] : 32'h0;
    fifo_level = level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over everything: flush, reload, hold state for this edge.
      pc_q     <= {redirect_pc[31:4], 4'b0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle:  if (fetch_en)  state_q <= StRun;
        StRun:   if (!fetch_en) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        pc_q     <= pc_q + 32'(PC_STEP);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + (PtrW + 1)'(1);
        2'b01:   level_q <= level_q - (PtrW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; level_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= rom_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a cycle model queues expected {pc, inst} on each
// fetch and retires them as decode accepts the FIFO head.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [63:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
  } entry_t;

  entry_t      sb_q[$];
  logic [31:0] popped_pc[$];
  logic [31:0] m_pc;
  bit          m_run;
  logic [31:0] last_pc;
  int          n_seen;

  inst_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .PC_STEP    (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fifo_level     (fifo_level)
  );

  function automatic logic [63:0] rom_fn(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a};
  endfunction

  assign rom_inst = rom_fn(rom_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] popped_at(input int i);
    if (popped_pc.size() > i) return popped_pc[i];
    return 32'hBAD0_BAD0;
  endfunction

  // Called at posedge+1 with inputs already set; checks at negedge, advances model at posedge.
  task automatic cycle();
    bit     m_pop, m_push;
    entry_t head;
    @(negedge clk);
    m_pop  = (sb_q.size() > 0) && out_ready;
    m_push = m_run && !redirect_valid && ((sb_q.size() < 2) || m_pop);
    check_val("rom_ce", 96'(rom_ce), 96'(m_push));
    check_val("rom_addr", 96'(rom_addr), 96'(m_push ? m_pc : 32'h0));
    check_val("fifo_level", 96'(fifo_level), 96'(sb_q.size()));
    check_val("out_valid", 96'(out_valid), 96'(sb_q.size() > 0));
    if (sb_q.size() > 0) begin
      head = sb_q[0];
      check_val("out_pc", 96'(out_pc), 96'(head.pc));
      check_val("out_inst", 96'(out_inst), 96'(head.inst));
      if (m_pop) popped_pc.push_back(head.pc);
    end else begin
      check_val("out_pc_idle", 96'(out_pc), 96'h0);
      check_val("out_inst_idle", 96'(out_inst), 96'h0);
    end
    if (redirect_valid) begin
      sb_q.delete();
      m_pc = {redirect_pc[31:4], 4'h0};
    end else begin
      if (m_pop) void'(sb_q.pop_front());
      if (m_push) begin
        sb_q.push_back({m_pc, rom_fn(m_pc)});
        m_pc = m_pc + 32'd16;
      end
      m_run = fetch_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb_q.delete();
    popped_pc.delete();
    m_pc  = 32'h0;
    m_run = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    #2;
    check_val("rst_rom_ce", 96'(rom_ce), 96'h0);
    check_val("rst_rom_addr", 96'(rom_addr), 96'h0);
    check_val("rst_out_valid", 96'(out_valid), 96'h0);
    check_val("rst_out_pc", 96'(out_pc), 96'h0);
    check_val("rst_level", 96'(fifo_level), 96'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming start
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    repeat (6) cycle();
    check_val("t1_pc0", 96'(popped_at(0)), 96'h00);
    check_val("t1_pc1", 96'(popped_at(1)), 96'h10);
    check_val("t1_pc2", 96'(popped_at(2)), 96'h20);

    // Backpressure until full, then resume with no gap/duplicate
    out_ready = 1'b0;
    repeat (5) cycle();
    check_val("t2_full", 96'(fifo_level), 96'h2);
    out_ready = 1'b1;
    repeat (6) cycle();
    for (int i = 1; i < popped_pc.size(); i++)
      check_val("t2_contig", 96'(popped_pc[i]), 96'(popped_pc[i-1] + 32'd16));

    // Redirect while full
    out_ready = 1'b0;
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h47;
    cycle();
    redirect_valid = 1'b0;
    check_val("t3_flush_valid", 96'(out_valid), 96'h0);
    check_val("t3_flush_level", 96'(fifo_level), 96'h0);
    out_ready = 1'b1;
    popped_pc.delete();
    repeat (5) cycle();
    check_val("t3_pc0", 96'(popped_at(0)), 96'h40);
    check_val("t3_pc1", 96'(popped_at(1)), 96'h50);

    // Pop and redirect in the same cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cycle();
    redirect_valid = 1'b0;
    popped_pc.delete();
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    cycle();
    redirect_valid = 1'b0;
    repeat (3) cycle();
    check_val("t4_pc0", 96'(popped_at(0)), 96'h00);
    check_val("t4_pc1", 96'(popped_at(1)), 96'h10);
    check_val("t4_pc2", 96'(popped_at(2)), 96'h80);
    n_seen = 0;
    foreach (popped_pc[i]) if (popped_pc[i] == 32'h10 || popped_pc[i] == 32'h20) n_seen++;
    check_val("t4_once", 96'(n_seen), 96'h1);

    // Disable with two buffered, drain, resume from saved pc
    out_ready = 1'b0;
    repeat (3) cycle();
    fetch_en = 1'b0;
    cycle();
    out_ready = 1'b1;
    popped_pc.delete();
    repeat (3) cycle();
    check_val("t5_drained", 96'(fifo_level), 96'h0);
    check_val("t5_npop", 96'(popped_pc.size()), 96'h2);
    last_pc = popped_at(1);
    fetch_en = 1'b1;
    popped_pc.delete();
    repeat (4) cycle();
    check_val("t5_resume", 96'(popped_at(0)), 96'(last_pc + 32'd16));

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    repeat (3) cycle();
    check_val("t6_pre_level", 96'(fifo_level), 96'h2);
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_out_valid", 96'(out_valid), 96'h0);
    check_val("t6_rom_ce", 96'(rom_ce), 96'h0);
    check_val("t6_level", 96'(fifo_level), 96'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (4) cycle();
    check_val("t6_first_pc", 96'(popped_at(0)), 96'h0);

    // PC wraps at 2^32
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF5;
    cycle();
    redirect_valid = 1'b0;
    popped_pc.delete();
    repeat (4) cycle();
    check_val("wrap_pc0", 96'(popped_at(0)), 96'hFFFF_FFF0);
    check_val("wrap_pc1", 96'(popped_at(1)), 96'h0);

    // Mixed random traffic
    for (int i = 0; i < 300; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      fetch_en       = ($urandom_range(0, 7) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
